// File: rtl/aes_round_ctrl_if.sv
// Block-side and round-logic-side signals of the iterative AES-128 sequencer.
// The slave modport is the sequencer's view; master is the driving environment's view.
interface aes_round_ctrl_if #(
    parameter int STATE_W = 128
);
    logic               in_valid;
    logic               in_ready;
    logic [STATE_W-1:0] in_text;
    logic [STATE_W-1:0] in_key;
    logic               out_valid;
    logic               out_ready;
    logic [STATE_W-1:0] out_text;
    logic               busy;
    logic [STATE_W-1:0] dp_state;
    logic [STATE_W-1:0] dp_rkey;
    logic               dp_final;
    logic [STATE_W-1:0] dp_next;
    logic [STATE_W-1:0] kx_key;
    logic [7:0]         kx_rcon;
    logic [STATE_W-1:0] kx_next_key;

    modport slave (
        input  in_valid, in_text, in_key, out_ready, dp_next, kx_next_key,
        output in_ready, out_valid, out_text, busy, dp_state, dp_rkey, dp_final, kx_key, kx_rcon
    );

    modport master (
        output in_valid, in_text, in_key, out_ready, dp_next, kx_next_key,
        input  in_ready, out_valid, out_text, busy, dp_state, dp_rkey, dp_final, kx_key, kx_rcon
    );
endinterface

// File: rtl/aes_round_ctrl.sv
// Iterative AES-128 encryption sequencer: state/key registers, round counter and Rcon, one round per clock.
// Optional AES_ROUND_CTRL_PERF_EN adds a 32-bit completed-block counter output blk_count.
module aes_round_ctrl #(
    parameter int NR      = 10,
    parameter int STATE_W = 128
) (
    input  logic        clk,
    input  logic        rst_n,
`ifdef AES_ROUND_CTRL_PERF_EN
    output logic [31:0] blk_count,
`endif
    aes_round_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ROUND = 2'd1,
        S_FINAL = 2'd2,
        S_DONE  = 2'd3
    } fsm_t;

    localparam logic [3:0] NR_M1 = 4'(NR - 1);

    fsm_t               r_fsm;
    fsm_t               w_fsm_nxt;
    logic [STATE_W-1:0] r_state;
    logic [STATE_W-1:0] r_key;
    logic [3:0]         r_round;
    logic [7:0]         r_rcon;
    logic               w_accept;
    logic               w_out_hs;
    logic               w_in_ready;
    logic               w_out_valid;
    logic               w_busy;
    logic               w_final;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    always_comb begin
        w_fsm_nxt   = r_fsm;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        w_busy      = 1'b0;
        w_final     = 1'b0;
        w_accept    = 1'b0;
        w_out_hs    = 1'b0;
        case (r_fsm)
            S_IDLE: begin
                w_in_ready = 1'b1;
                w_accept   = bus.in_valid;
                if (bus.in_valid) w_fsm_nxt = S_ROUND;
            end
            S_ROUND: begin
                w_busy = 1'b1;
                if (r_round == NR_M1) w_fsm_nxt = S_FINAL;
            end
            S_FINAL: begin
                w_busy    = 1'b1;
                w_final   = 1'b1;
                w_fsm_nxt = S_DONE;
            end
            S_DONE: begin
                w_out_valid = 1'b1;
                w_out_hs    = bus.out_ready;
                // A new block waits one cycle in IDLE even if in_valid is already high
                if (bus.out_ready) w_fsm_nxt = S_IDLE;
            end
            default: w_fsm_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_fsm <= S_IDLE;
        else        r_fsm <= w_fsm_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= '0;
            r_key   <= '0;
            r_round <= 4'd0;
            r_rcon  <= 8'h01;
        end else begin
            case (r_fsm)
                S_IDLE: begin
                    if (w_accept) begin
                        // Initial AddRoundKey is folded into the load
                        r_state <= bus.in_text ^ bus.in_key;
                        r_key   <= bus.in_key;
                        r_round <= 4'd1;
                        r_rcon  <= 8'h01;
                    end
                end
                S_ROUND: begin
                    r_state <= bus.dp_next;
                    r_key   <= bus.kx_next_key;
                    r_rcon  <= xtime(r_rcon);
                    r_round <= r_round + 4'd1;
                end
                S_FINAL: begin
                    r_state <= bus.dp_next;
                    r_key   <= bus.kx_next_key;
                end
                default: ;
            endcase
        end
    end

`ifdef AES_ROUND_CTRL_PERF_EN
    logic [31:0] r_blk_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        r_blk_count <= 32'd0;
        else if (w_out_hs) r_blk_count <= r_blk_count + 32'd1;
    end

    assign blk_count = r_blk_count;
`else
    logic w_hs_unused;
    assign w_hs_unused = w_out_hs;
`endif

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_text  = r_state;
    assign bus.busy      = w_busy;
    assign bus.dp_state  = r_state;
    assign bus.dp_rkey   = bus.kx_next_key;
    assign bus.dp_final  = w_final;
    assign bus.kx_key    = r_key;
    assign bus.kx_rcon   = r_rcon;
endmodule
